// File: rtl/tk1_exec_monitor_if.sv
// tk1 register bus interface for the execution monitor.
// master: drives cs/we/address/write_data, samples read_data/ready.
// slave : samples cs/we/address/write_data, drives read_data/ready.
interface tk1_exec_monitor_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output cs, output we, output address, output write_data,
                  input  read_data, input ready);
  modport slave  (input  cs, input we, input address, input write_data,
                  output read_data, output ready);
endinterface

// File: rtl/tk1_exec_monitor.sv
// CPU execution monitor: NUM_REGIONS programmable trap windows plus the fixed
// firmware-RAM no-execute window, with write-once lock, first-violation
// capture and a saturating violation counter.
// Ports:
//   clk, reset_n     - clock, synchronous active-low reset
//   i_fw_app_mode    - 1 = application mode (STATUS clear ignored)
//   i_cpu_valid      - CPU access valid
//   i_cpu_instr      - access is an instruction fetch
//   i_cpu_addr       - CPU access address
//   o_force_trap     - combinational trap request, same cycle as access
//   bus              - tk1 register bus (slave)
module tk1_exec_monitor #(
  parameter int unsigned NUM_REGIONS  = 4,
  parameter int unsigned CTR_WIDTH    = 16,
  parameter logic [31:0] FW_RAM_FIRST = 32'hd0000000,
  parameter logic [31:0] FW_RAM_LAST  = 32'hd00007ff
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_fw_app_mode,
  input  logic                 i_cpu_valid,
  input  logic                 i_cpu_instr,
  input  logic [31:0]          i_cpu_addr,
  output logic                 o_force_trap,
  tk1_exec_monitor_if.slave    bus
);

  localparam int unsigned IDX_W = 3;
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_VADDR  = 8'h02;
  localparam logic [7:0] ADDR_VCOUNT = 8'h03;
  localparam logic [7:0] ADDR_EN     = 8'h08;
  localparam logic [7:0] ADDR_MODE   = 8'h09;
  localparam logic [3:0] FW_REGION   = 4'hf;

  logic                   r_lock;
  logic [NUM_REGIONS-1:0] r_en;
  logic [NUM_REGIONS-1:0] r_mode;
  logic [31:0]            r_first [NUM_REGIONS];
  logic [31:0]            r_last  [NUM_REGIONS];
  logic                   r_viol;
  logic [3:0]             r_viol_region;
  logic [31:0]            r_viol_addr;
  logic [CTR_WIDTH-1:0]   r_cnt;

  logic                   w_wr;
  logic                   w_rgn_sel;
  logic                   w_clr;
  logic                   w_hit_fw;
  logic [NUM_REGIONS-1:0] w_hit;
  logic [IDX_W-1:0]       w_hit_idx;
  logic [3:0]             w_region;
  logic [31:0]            w_rdata;

  assign w_wr      = bus.cs & bus.we;
  // FIRST_i/LAST_i live at 0x10+2i / 0x11+2i; beyond the last window is unmapped
  assign w_rgn_sel = (bus.address[7:4] == 4'h1) &&
                     ({1'b0, bus.address[3:1]} < 4'(NUM_REGIONS));
  assign w_clr     = w_wr && (bus.address == ADDR_STATUS) &&
                     bus.write_data[0] && !i_fw_app_mode;

  // Window match; programmable windows are gated by reset_n so that during
  // reset only the fixed firmware window can trap, as after reset.
  always_comb begin
    w_hit_fw = i_cpu_valid && i_cpu_instr &&
               (i_cpu_addr >= FW_RAM_FIRST) && (i_cpu_addr <= FW_RAM_LAST);
    w_hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      w_hit[i] = reset_n && i_cpu_valid && r_en[i] && (i_cpu_instr || r_mode[i]) &&
                 (i_cpu_addr >= r_first[i]) && (i_cpu_addr <= r_last[i]);
    end
    w_hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = IDX_W'(i);
    end
    w_region = w_hit_fw ? FW_REGION : {1'b0, w_hit_idx};
  end

  assign o_force_trap = w_hit_fw | (|w_hit);

  // Register file, capture and counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lock        <= 1'b0;
      r_en          <= '0;
      r_mode        <= '0;
      r_viol        <= 1'b0;
      r_viol_region <= '0;
      r_viol_addr   <= '0;
      r_cnt         <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_first[i] <= '0;
        r_last[i]  <= '0;
      end
    end else begin
      if (w_wr && (bus.address == ADDR_CTRL) && bus.write_data[0]) r_lock <= 1'b1;

      // Lock takes effect from the cycle after the CTRL write
      if (w_wr && !r_lock) begin
        if (bus.address == ADDR_EN)   r_en   <= bus.write_data[NUM_REGIONS-1:0];
        if (bus.address == ADDR_MODE) r_mode <= bus.write_data[NUM_REGIONS-1:0];
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (w_rgn_sel && (bus.address[3:1] == IDX_W'(i))) begin
            if (bus.address[0]) r_last[i]  <= bus.write_data;
            else                r_first[i] <= bus.write_data;
          end
        end
      end

      if (o_force_trap && (r_cnt != '1)) r_cnt <= r_cnt + CTR_WIDTH'(1);

      // A new violation beats a same-cycle clear
      if (o_force_trap && (!r_viol || w_clr)) begin
        r_viol        <= 1'b1;
        r_viol_region <= w_region;
        r_viol_addr   <= i_cpu_addr;
      end else if (w_clr) begin
        r_viol        <= 1'b0;
        r_viol_region <= '0;
        r_viol_addr   <= '0;
      end
    end
  end

  // Read mux: zero when idle, on writes and for unmapped addresses
  always_comb begin
    w_rdata = '0;
    if (bus.cs && !bus.we) begin
      case (bus.address)
        ADDR_CTRL:   w_rdata = {31'h0, r_lock};
        ADDR_STATUS: w_rdata = {24'h0, r_viol_region, 3'b000, r_viol};
        ADDR_VADDR:  w_rdata = r_viol_addr;
        ADDR_VCOUNT: w_rdata = 32'(r_cnt);
        ADDR_EN:     w_rdata = 32'(r_en);
        ADDR_MODE:   w_rdata = 32'(r_mode);
        default: begin
          for (int i = 0; i < NUM_REGIONS; i++) begin
            if (w_rgn_sel && (bus.address[3:1] == IDX_W'(i))) begin
              w_rdata = bus.address[0] ? r_last[i] : r_first[i];
            end
          end
        end
      endcase
    end
  end

  assign bus.read_data = w_rdata;
  assign bus.ready     = bus.cs;

endmodule

// File: tb/tb_tk1_exec_monitor.sv
// Directed self-checking bench for tk1_exec_monitor (CTR_WIDTH=4 so that
// counter saturation is reachable in a short run).
module tb_tk1_exec_monitor;

  logic        clk;
  logic        reset_n;
  logic        fw_app_mode;
  logic        cpu_valid;
  logic        cpu_instr;
  logic [31:0] cpu_addr;
  logic        force_trap;
  int          n_checks;
  int          n_errors;

  tk1_exec_monitor_if bus_if ();

  tk1_exec_monitor #(
    .NUM_REGIONS (4),
    .CTR_WIDTH   (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_fw_app_mode (fw_app_mode),
    .i_cpu_valid   (cpu_valid),
    .i_cpu_instr   (cpu_instr),
    .i_cpu_addr    (cpu_addr),
    .o_force_trap  (force_trap),
    .bus           (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.address = a; bus_if.write_data = d;
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.address = a;
    #1;
    chk(tag, bus_if.read_data, exp);
    bus_if.cs = 1'b0;
  endtask

  // One-cycle CPU access: trap checked before the capturing edge
  task automatic cpu_acc(input logic instr, input logic [31:0] a, input logic exp, input string tag);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = a;
    #1;
    chk(tag, 32'(force_trap), 32'(exp));
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; fw_app_mode = 1'b0;
    cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0;
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.address = '0; bus_if.write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    bus_rd(8'h00, 32'h0, "rst_ctrl");
    bus_rd(8'h01, 32'h0, "rst_status");
    bus_rd(8'h03, 32'h0, "rst_count");
    bus_rd(8'h08, 32'h0, "rst_en");
    bus_rd(8'h12, 32'h0, "rst_first1");
    @(negedge clk); bus_if.cs = 1'b1; #1;
    chk("ready_eq_cs", 32'(bus_if.ready), 32'h1);
    bus_if.cs = 1'b0; #1;
    chk("ready_idle", 32'(bus_if.ready), 32'h0);

    // Fixed firmware window (count 1, 2)
    cpu_acc(1'b1, 32'hd0000100, 1'b1, "fw_fetch");
    bus_rd(8'h01, 32'h000000f1, "fw_status");
    bus_rd(8'h02, 32'hd0000100, "fw_vaddr");
    bus_rd(8'h03, 32'd1, "fw_count1");
    cpu_acc(1'b0, 32'hd0000100, 1'b0, "fw_data");
    cpu_acc(1'b1, 32'hd00007ff, 1'b1, "fw_last");
    cpu_acc(1'b1, 32'hd0000800, 1'b0, "fw_above");
    cpu_acc(1'b1, 32'hcfffffff, 1'b0, "fw_below");
    bus_rd(8'h02, 32'hd0000100, "fw_vaddr_hold");
    bus_rd(8'h03, 32'd2, "fw_count2");
    bus_wr(8'h01, 32'h1);
    bus_rd(8'h01, 32'h0, "clr_status");
    bus_rd(8'h02, 32'h0, "clr_vaddr");

    // Window 1 (count 3, 4)
    bus_wr(8'h12, 32'h40001000);
    bus_wr(8'h13, 32'h40001fff);
    bus_wr(8'h08, 32'h2);
    bus_wr(8'h09, 32'h0);
    cpu_acc(1'b1, 32'h40001ffc, 1'b1, "w1_fetch");
    bus_rd(8'h01, 32'h00000011, "w1_status");
    bus_rd(8'h02, 32'h40001ffc, "w1_vaddr");
    cpu_acc(1'b0, 32'h40001ffc, 1'b0, "w1_data_nomode");
    bus_wr(8'h09, 32'h2);
    cpu_acc(1'b0, 32'h40001ffc, 1'b1, "w1_data_mode");
    cpu_acc(1'b0, 32'h40002000, 1'b0, "w1_above");
    cpu_acc(1'b1, 32'h40000fff, 1'b0, "w1_below");
    bus_rd(8'h03, 32'd4, "w1_count");
    bus_rd(8'h18, 32'h0, "unmapped_18");
    bus_rd(8'h04, 32'h0, "unmapped_04");

    // Overlapping windows 0 and 2 (count 5, 6), inverted window 3
    bus_wr(8'h01, 32'h1);
    bus_wr(8'h10, 32'h50000000);
    bus_wr(8'h11, 32'h500000ff);
    bus_wr(8'h14, 32'h50000080);
    bus_wr(8'h15, 32'h500001ff);
    bus_wr(8'h08, 32'h7);
    cpu_acc(1'b1, 32'h50000090, 1'b1, "ovl_fetch");
    bus_rd(8'h01, 32'h00000001, "ovl_region0");
    cpu_acc(1'b1, 32'h50000100, 1'b1, "ovl_second");
    bus_rd(8'h02, 32'h50000090, "ovl_vaddr_hold");
    bus_rd(8'h03, 32'd6, "ovl_count");
    bus_wr(8'h16, 32'h60000010);
    bus_wr(8'h17, 32'h60000000);
    bus_wr(8'h08, 32'hf);
    cpu_acc(1'b1, 32'h60000008, 1'b0, "inv_mid");
    cpu_acc(1'b1, 32'h60000010, 1'b0, "inv_first");

    // STATUS clear rules (count 7, 8)
    fw_app_mode = 1'b1;
    bus_wr(8'h01, 32'h1);
    bus_rd(8'h01, 32'h00000001, "clr_app_mode");
    fw_app_mode = 1'b0;
    bus_wr(8'h01, 32'h1);
    bus_rd(8'h01, 32'h0, "clr_fw_mode");
    cpu_acc(1'b1, 32'h50000010, 1'b1, "pre_sim_fetch");
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.address = 8'h01; bus_if.write_data = 32'h1;
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'h40001004;
    #1;
    chk("rdata_on_write", bus_if.read_data, 32'h0);
    @(posedge clk); #1;
    bus_if.cs = 1'b0; bus_if.we = 1'b0; cpu_valid = 1'b0;
    bus_rd(8'h01, 32'h00000011, "sim_status");
    bus_rd(8'h02, 32'h40001004, "sim_vaddr");
    bus_rd(8'h03, 32'd8, "sim_count");

    // Lock
    bus_wr(8'h00, 32'h1);
    bus_rd(8'h00, 32'h1, "lock_set");
    bus_wr(8'h08, 32'h0);
    bus_wr(8'h12, 32'h0);
    bus_wr(8'h09, 32'h0);
    bus_rd(8'h08, 32'hf, "lock_en");
    bus_rd(8'h12, 32'h40001000, "lock_first1");
    bus_rd(8'h09, 32'h2, "lock_mode");
    bus_wr(8'h00, 32'h0);
    bus_rd(8'h00, 32'h1, "lock_sticky");
    bus_wr(8'h03, 32'h0);
    bus_rd(8'h03, 32'd8, "count_ro");
    @(negedge clk); bus_if.address = 8'h00; #1;
    chk("rdata_no_cs", bus_if.read_data, 32'h0);

    // Saturation: 20 trapping cycles from 8 -> 15
    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'hd0000000;
    repeat (20) @(posedge clk);
    #1 cpu_valid = 1'b0;
    bus_rd(8'h03, 32'd15, "sat_count");
    bus_rd(8'h02, 32'h40001004, "sat_vaddr_hold");

    // Reset mid-burst
    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'h40001000;
    #1 chk("burst_w1", 32'(force_trap), 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    #1 chk("rst_w1_gated", 32'(force_trap), 32'h0);
    cpu_addr = 32'hd0000000;
    #1 chk("rst_fw_active", 32'(force_trap), 32'h1);
    @(negedge clk);
    reset_n = 1'b1; cpu_valid = 1'b0;
    bus_rd(8'h00, 32'h0, "mid_ctrl");
    bus_rd(8'h01, 32'h0, "mid_status");
    bus_rd(8'h02, 32'h0, "mid_vaddr");
    bus_rd(8'h03, 32'h0, "mid_count");
    bus_rd(8'h08, 32'h0, "mid_en");
    bus_rd(8'h09, 32'h0, "mid_mode");
    bus_rd(8'h13, 32'h0, "mid_last1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
